// File: rtl/mlt3_pkg.sv
// Shared encodings for the MLT-3 lane decoder: line levels and lock FSM states.
package mlt3_pkg;
  typedef logic [1:0] lvl_t;

  localparam lvl_t LVL_ZERO = 2'b00;
  localparam lvl_t LVL_POS  = 2'b01;
  localparam lvl_t LVL_NEG  = 2'b10;
  localparam lvl_t LVL_ILL  = 2'b11;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} lock_state_t;
endpackage

// File: rtl/mlt3_lane_dec.sv
// One MLT-3 lane: tracks previous level and last nonzero polarity, decodes a bit
// and flags illegal symbols / sequence violations combinationally for this beat.
module mlt3_lane_dec
  import mlt3_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  lvl_t sym_i,
  input  logic valid_i,
  input  logic clr_pol_i,
  output logic data_o,
  output logic err_o
);

  lvl_t prev_q, prev_d;
  logic pol_pos_q, pol_pos_d;
  logic pol_known_q, pol_known_d;

  always_comb begin
    prev_d      = prev_q;
    pol_pos_d   = pol_pos_q;
    pol_known_d = pol_known_q;
    data_o      = 1'b0;
    err_o       = 1'b0;
    if (valid_i) begin
      if (sym_i == LVL_ILL) begin
        err_o = 1'b1;
      end else begin
        if (sym_i != prev_q) begin
          data_o = 1'b1;
          prev_d = sym_i;
          // Direct +1<->-1 jump, or returning from zero to the same polarity.
          err_o  = (prev_q != LVL_ZERO && sym_i != LVL_ZERO) ||
                   (pol_known_q && prev_q == LVL_ZERO &&
                    ((sym_i == LVL_POS) == pol_pos_q));
        end
        if (sym_i != LVL_ZERO) begin
          pol_pos_d   = (sym_i == LVL_POS);
          pol_known_d = 1'b1;
        end
      end
      if (clr_pol_i) pol_known_d = 1'b0;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= LVL_ZERO;
      pol_pos_q   <= 1'b0;
      pol_known_q <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      pol_pos_q   <= pol_pos_d;
      pol_known_q <= pol_known_d;
    end
  end

endmodule

// File: rtl/mlt3_dec_lanes.sv
// Multi-lane MLT-3 decoder top: per-lane decoders plus registered outputs,
// HUNT/LOCKED lock tracking and a saturating errored-beat counter.
module mlt3_dec_lanes
  import mlt3_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int LOCK_LEN    = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*LANES-1:0]   sym_i,
  input  logic                 sym_valid_i,
  input  logic                 err_clr_i,
  output logic [LANES-1:0]     data_o,
  output logic                 data_valid_o,
  output logic [LANES-1:0]     lane_err_o,
  output logic                 locked_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int GW = $clog2(LOCK_LEN + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);
  localparam logic [GW-1:0] LOCK_LEN_C    = GW'(LOCK_LEN);
  localparam logic [BW-1:0] UNLOCK_ERRS_C = BW'(UNLOCK_ERRS);

  logic [LANES-1:0] lane_data, lane_err;
  logic             beat_err, clr_pol;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    mlt3_lane_dec u_lane (
      .clk      (clk),
      .rst      (rst),
      .sym_i    (sym_i[2*n+1:2*n]),
      .valid_i  (sym_valid_i),
      .clr_pol_i(clr_pol),
      .data_o   (lane_data[n]),
      .err_o    (lane_err[n])
    );
  end

  assign beat_err = sym_valid_i && (|lane_err);

  lock_state_t          state_q, state_d;
  logic [GW-1:0]        good_cnt_q, good_cnt_d;
  logic [BW-1:0]        bad_cnt_q, bad_cnt_d;
  logic [LANES-1:0]     data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic [LANES-1:0]     lane_err_q, lane_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    clr_pol    = 1'b0;
    if (sym_valid_i) begin
      case (state_q)
        HUNT: begin
          if (beat_err) begin
            good_cnt_d = '0;
          end else if (good_cnt_q + GW'(1) == LOCK_LEN_C) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + GW'(1);
          end
        end
        LOCKED: begin
          if (!beat_err) begin
            bad_cnt_d = '0;
          end else if (bad_cnt_q + BW'(1) == UNLOCK_ERRS_C) begin
            state_d   = HUNT;
            bad_cnt_d = '0;
            clr_pol   = 1'b1;
          end else begin
            bad_cnt_d = bad_cnt_q + BW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    data_d       = sym_valid_i ? lane_data : data_q;
    data_valid_d = sym_valid_i;
    lane_err_d   = sym_valid_i ? lane_err : '0;
    err_cnt_d    = err_cnt_q;
    // Clear wins over a same-edge increment.
    if (err_clr_i)                  err_cnt_d = '0;
    else if (beat_err && !(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      lane_err_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      lane_err_q   <= lane_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = data_valid_q;
  assign lane_err_o   = lane_err_q;
  assign locked_o     = (state_q == LOCKED);
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: doc/mlt3_dec_lanes.md
Name: mlt3_dec_lanes

Overview:
Parametrised multi-lane MLT-3 line decoder. Each lane recovers one data bit per symbol: a level change decodes as 1, no change as 0. It also detects illegal symbols and MLT-3 sequence (polarity) violations, and tracks link lock through a HUNT/LOCKED state machine with a saturating error counter. It sits directly behind the line receiver and feeds the descrambler/deframer.

Parameters:
LANES, 4, number of parallel symbol lanes
LOCK_LEN, 8, consecutive clean valid beats required to enter LOCKED
UNLOCK_ERRS, 4, consecutive errored valid beats that drop LOCKED back to HUNT
ERR_CNT_W, 16, width of the saturating error counter

Ports:
clk  in  1  symbol clock; all state samples on the falling edge
rst  in  1  asynchronous reset, active-high
sym_i  in  2*LANES  lane n symbol at [2n+1:2n]; 00=zero, 01=+1, 10=-1, 11=illegal
sym_valid_i  in  1  symbols valid this beat
err_clr_i  in  1  clears err_cnt_o
data_o  out  LANES  decoded bits
data_valid_o  out  1  data_o/lane_err_o valid
lane_err_o  out  LANES  per-lane error flag for this beat
locked_o  out  1  lock FSM is in LOCKED
err_cnt_o  out  ERR_CNT_W  count of errored beats, saturating

Behaviour:
- Reset (asynchronous, active-high) values: data_o=0, data_valid_o=0, lane_err_o=0, locked_o=0, err_cnt_o=0, FSM=HUNT, all counters=0. Per lane: prev level=zero, polarity-known=0.
- All state updates on the falling edge of clk. Outputs are registered and reflect the symbol sampled at that same edge (one register stage).
- sym_valid_i=0: data_valid_o=0, lane_err_o=0, data_o holds. No lane, FSM or counter state changes.
- Per-lane rules on a valid beat, in priority order:
  - sym=11: lane_err=1, data=0. Prev level and last nonzero polarity are unchanged.
  - sym==prev: data=0, no error.
  - sym!=prev: data=1, prev<=sym. Error if +1<->-1 is a direct jump, or if polarity-known and a 0->nonzero step repeats the last nonzero polarity. data stays 1 on such an error.
  - Any nonzero symbol records last polarity and sets polarity-known.
- beat_err = OR of lane_err over all lanes (valid beats only).
- Lock FSM:
  - HUNT: clean beat increments good_cnt; beat_err clears it. Transition to LOCKED when good_cnt reaches LOCK_LEN; locked_o=1 at that same edge. good_cnt then clears.
  - LOCKED: beat_err increments bad_cnt; a clean beat clears it. Transition to HUNT when bad_cnt reaches UNLOCK_ERRS; locked_o=0 at that edge, and polarity-known clears in all lanes.
  - Invalid beats freeze both counters.
- err_cnt_o: +1 per valid beat with beat_err, saturating at all-ones. err_clr_i has priority: if clear and error occur on the same edge, the result is 0.
- data_o is produced in both FSM states; gating by lock is the consumer's job.
- A reset asserted mid-stream returns everything to reset values immediately, without waiting for a clock edge.

Decomposition:
- Package mlt3_pkg: level encodings LVL_ZERO/LVL_POS/LVL_NEG/LVL_ILL, typedef lvl_t (logic [1:0]), enum lock_state_t {HUNT, LOCKED}.
- Sub-module mlt3_lane_dec: one instance per lane, generate loop. It holds prev level, last polarity and polarity-known, and outputs data and lane_err. The top holds the FSM and counters.

Test Plan:
(LANES=2, LOCK_LEN=4, UNLOCK_ERRS=2, ERR_CNT_W=3)
- Reset, lane0 symbols 00,01,01,00,10,00 (all valid) -> data_o[0]=0,1,0,1,1,1; lane_err_o=0; err_cnt_o=0.
- Lane1 sends 11 after prev=01, then 00 -> first beat lane_err_o=2'b10, data_o[1]=0, err_cnt_o=1. Next beat data_o[1]=1 (01->00), no error.
- Lane0 prev=01, sends 10 -> data_o[0]=1, lane_err_o[0]=1. Separately, sequence 01,00,01 -> second 01 flagged as polarity error.
- 4 clean valid beats from reset -> locked_o rises at the 4th edge. Then 2 consecutive errored beats -> locked_o falls at the 2nd. Error, clean, error -> stays LOCKED.
- sym_valid_i low for 3 beats mid-stream with changing sym_i -> data_valid_o=0, data_o held, counters frozen. Resume with the same level -> data=0.
- 9 errored beats -> err_cnt_o saturates at 7. err_clr_i together with an errored beat -> err_cnt_o=0. Assert rst mid-LOCKED -> all outputs 0 immediately, FSM in HUNT.
